conv_bf16tomx_seq: RTL and testbench
====================================

CONV_BF16TOMX_SEQ -- requirements
Module: conv_bf16tomx_seq

Interface
REQ-001 SHALL have parameter k, default 32, elements per MX block.
REQ-002 SHALL have parameter bit_width, default 8, MX element width.
REQ-003 SHALL have parameter conv_lat, default 1, fixed converter latency in cycles, range 1..15.
REQ-004 SHALL have parameter out_depth, default 2, output buffer depth in blocks, range 1..4.
REQ-005 SHALL have one clock; reset is asynchronous and active-high:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
REQ-006 SHALL have these data ports:
- i_valid  in  1  input element valid
- o_ready  out  1  input element accepted when i_valid & o_ready
- i_bf16  in  16  bf16 element
- i_last  in  1  final element of a partial block
- o_conv_vec  out  16*k  block to converter, element j at [16j+15:16j]
- o_conv_issue  out  1  single-cycle pulse, o_conv_vec valid
- i_conv_mx_vec  in  bit_width*k  converter element results
- i_conv_mx_exp  in  8  converter shared exponent
- o_valid  out  1  output block valid
- i_ready  in  1  output block consumed when o_valid & i_ready
- o_mx_vec  out  bit_width*k  output elements
- o_mx_exp  out  8  output shared exponent
- o_count  out  $clog2(k+1)  number of real (non-pad) elements in output block

Function
REQ-007 SHALL run an FSM with states FILL and WAIT_CREDIT; reset state is FILL.
REQ-008 In FILL, o_ready SHALL be 1; each accepted element is written to slot fill_idx, and fill_idx increments.
REQ-009 A block SHALL close when slot k-1 is written or when an element with i_last=1 is accepted. Slots not written SHALL be zero (16'h0000).
REQ-010 When a block closes and credit > 0, o_conv_issue SHALL pulse on the next cycle, fill_idx SHALL return to 0, and the FSM SHALL stay in FILL. Otherwise the FSM SHALL go to WAIT_CREDIT.
REQ-011 In WAIT_CREDIT, o_ready SHALL be 0. When credit > 0, o_conv_issue SHALL pulse and the FSM SHALL go to FILL.
REQ-012 credit SHALL equal out_depth minus (blocks in flight + blocks held in the output buffer). It SHALL never go negative, so the output buffer never overflows.
REQ-013 In-flight tracking SHALL be a conv_lat-deep valid shift register tagged with the block's count. The converter result SHALL be captured into the output FIFO exactly conv_lat cycles after o_conv_issue.
REQ-014 o_conv_vec SHALL remain stable from o_conv_issue until the next block begins filling.
REQ-015 The output FIFO SHALL be in order, hold out_depth entries, and present the head on o_mx_vec, o_mx_exp and o_count with o_valid=1 when it is non-empty.
REQ-016 When a capture and a pop happen in the same cycle, the FIFO occupancy and credit SHALL be unchanged.
REQ-017 Credit returned by a pop SHALL be usable for an issue in the same cycle.
REQ-018 With i_ready held at 1, block throughput SHALL be one block per k accepted elements, with no bubbles.

Reset
REQ-019 Reset SHALL set o_ready=1, o_conv_issue=0, o_valid=0, o_mx_vec=0, o_mx_exp=0, o_count=0, fill_idx=0, FSM=FILL.
REQ-020 Reset SHALL set o_conv_vec to 0, clear the in-flight register and the FIFO, and set credit to out_depth.
REQ-021 A reset mid-operation SHALL discard the partial block, all in-flight blocks and all buffered blocks. Converter results arriving after reset SHALL be ignored.

Configuration
REQ-022 Macro CONV_SEQ_PERF_CNT_EN SHALL gate performance counters.
- Defined: add 32-bit outputs o_blk_cnt (incremented per o_conv_issue) and o_stall_cnt (incremented each WAIT_CREDIT cycle). Both saturate at 32'hFFFFFFFF and reset to 0.
- Not defined: these ports and counters are absent, and all other behaviour is identical.

Verification
REQ-023 64 back-to-back elements, i_ready=1, conv_lat=1 -> two o_conv_issue pulses 32 cycles apart; two output blocks with o_count=32; o_ready never drops.
REQ-024 5 elements with i_last on the 5th -> one issue; slots 5..31 are 16'h0000; o_count=5.
REQ-025 i_ready=0, out_depth=2, 96 elements -> two blocks buffered; FSM in WAIT_CREDIT; o_ready=0. Raising i_ready for 1 cycle -> third block issues in that same cycle.
REQ-026 conv_lat=4 with pop and capture in the same cycle -> FIFO occupancy unchanged, and output order matches issue order.
REQ-027 i_rst asserted 2 cycles after an issue with conv_lat=4 -> o_valid stays 0 after reset and no stale block appears.
REQ-028 With CONV_SEQ_PERF_CNT_EN defined, 3 blocks issued with 7 stall cycles -> o_blk_cnt=3 and o_stall_cnt=7.

Source files
------------

// File: rtl/conv_bf16tomx_seq.sv
// Collects bf16 elements into k-wide blocks, issues them to a fixed-latency MX converter and
// buffers results in an in-order FIFO under credit control. CONV_SEQ_PERF_CNT_EN adds perf counters.
module conv_bf16tomx_seq #(
   parameter int k         = 32,
   parameter int bit_width = 8,
   parameter int conv_lat  = 1,
   parameter int out_depth = 2
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_valid,
   output logic                      o_ready,
   input  logic [15:0]               i_bf16,
   input  logic                      i_last,
   output logic [16*k-1:0]           o_conv_vec,
   output logic                      o_conv_issue,
   input  logic [bit_width*k-1:0]    i_conv_mx_vec,
   input  logic [7:0]                i_conv_mx_exp,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic [bit_width*k-1:0]    o_mx_vec,
   output logic [7:0]                o_mx_exp,
   output logic [$clog2(k+1)-1:0]    o_count
`ifdef CONV_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]               o_blk_cnt,
   output logic [31:0]               o_stall_cnt
`endif
);
   localparam int IW = (k > 1) ? $clog2(k) : 1;
   localparam int CW = $clog2(k + 1);
   localparam int PW = (out_depth > 1) ? $clog2(out_depth) : 1;
   localparam int OW = $clog2(out_depth + 1);
   localparam int MW = bit_width * k;
   localparam logic [IW-1:0] LAST_IDX = IW'(k - 1);

   typedef enum logic {FILL, WAIT_CREDIT} state_e;

   state_e             state_q;
   logic [IW-1:0]      fill_idx_q;
   logic [k-1:0][15:0] buf_q, buf_d;
   logic [CW-1:0]      tag_q;
   logic               issue_q;
   logic [OW-1:0]      credit_q, credit_d;
   logic [conv_lat:1]  vld_pipe_q;
   logic [CW-1:0]      cnt_pipe_q [1:conv_lat];
   logic [MW-1:0]      fmx_q  [out_depth];
   logic [7:0]         fexp_q [out_depth];
   logic [CW-1:0]      fcnt_q [out_depth];
   logic [PW-1:0]      wr_q, rd_q;
   logic [OW-1:0]      occ_q;
   logic               accept, close, pop, avail, wait_issue, issue_dec, capture;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(out_depth - 1)) ? '0 : p + PW'(1);
   endfunction

   assign o_ready      = (state_q == FILL);
   assign accept       = i_valid & o_ready;
   assign close        = accept & ((fill_idx_q == LAST_IDX) | i_last);
   assign pop          = o_valid & i_ready;
   // A pop frees a slot this cycle, so its credit can be spent immediately.
   assign avail        = (credit_q != '0) | pop;
   assign wait_issue   = (state_q == WAIT_CREDIT) & avail;
   assign issue_dec    = (close & avail) | wait_issue;
   assign o_conv_issue = issue_q | wait_issue;
   assign o_conv_vec   = buf_q;
   assign capture      = vld_pipe_q[conv_lat];

   // First element of a block clears the rest so unwritten slots read as zero.
   always_comb begin
      buf_d = (fill_idx_q == '0) ? '0 : buf_q;
      buf_d[fill_idx_q] = i_bf16;
   end

   always_comb begin
      credit_d = credit_q;
      case ({pop, issue_dec})
         2'b10:   credit_d = credit_q + OW'(1);
         2'b01:   credit_d = credit_q - OW'(1);
         default: credit_d = credit_q;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= FILL;
         fill_idx_q <= '0;
         buf_q      <= '0;
         tag_q      <= '0;
         issue_q    <= 1'b0;
         credit_q   <= OW'(out_depth);
      end else begin
         issue_q  <= 1'b0;
         credit_q <= credit_d;
         if (accept) begin
            buf_q      <= buf_d;
            fill_idx_q <= close ? '0 : fill_idx_q + IW'(1);
         end
         if (close) begin
            tag_q <= CW'(fill_idx_q) + CW'(1);
            if (avail) issue_q <= 1'b1;
            else       state_q <= WAIT_CREDIT;
         end
         if (wait_issue) state_q <= FILL;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         vld_pipe_q <= '0;
         for (int i = 1; i <= conv_lat; i++) cnt_pipe_q[i] <= '0;
      end else begin
         vld_pipe_q[1] <= o_conv_issue;
         cnt_pipe_q[1] <= tag_q;
         for (int i = 2; i <= conv_lat; i++) begin
            vld_pipe_q[i] <= vld_pipe_q[i-1];
            cnt_pipe_q[i] <= cnt_pipe_q[i-1];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         occ_q <= '0;
         for (int i = 0; i < out_depth; i++) begin
            fmx_q[i]  <= '0;
            fexp_q[i] <= '0;
            fcnt_q[i] <= '0;
         end
      end else begin
         if (capture) begin
            fmx_q[wr_q]  <= i_conv_mx_vec;
            fexp_q[wr_q] <= i_conv_mx_exp;
            fcnt_q[wr_q] <= cnt_pipe_q[conv_lat];
            wr_q         <= ptr_inc(wr_q);
         end
         if (pop) rd_q <= ptr_inc(rd_q);
         if (capture && !pop)      occ_q <= occ_q + OW'(1);
         else if (!capture && pop) occ_q <= occ_q - OW'(1);
      end
   end

   assign o_valid  = (occ_q != '0);
   assign o_mx_vec = fmx_q[rd_q];
   assign o_mx_exp = fexp_q[rd_q];
   assign o_count  = fcnt_q[rd_q];

`ifdef CONV_SEQ_PERF_CNT_EN
   logic [31:0] blk_cnt_q, stall_cnt_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         blk_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (o_conv_issue && blk_cnt_q != '1) blk_cnt_q <= blk_cnt_q + 32'd1;
         if (state_q == WAIT_CREDIT && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign o_blk_cnt   = blk_cnt_q;
   assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_conv_bf16tomx_seq.sv
// Bench for conv_bf16tomx_seq: mock converter, block-level scoreboard and directed scenarios.
module tb_conv_bf16tomx_seq;
   localparam int K = 32, BW = 8, LAT = 4, DEPTH = 2, CW = $clog2(K + 1);

   logic clk = 1'b0;
   logic rst, i_valid, i_last, i_ready;
   logic [15:0] i_bf16;
   logic o_ready, o_conv_issue, o_valid;
   logic [16*K-1:0] o_conv_vec;
   logic [K*BW-1:0] i_conv_mx_vec, o_mx_vec;
   logic [7:0] i_conv_mx_exp, o_mx_exp;
   logic [CW-1:0] o_count;
`ifdef CONV_SEQ_PERF_CNT_EN
   logic [31:0] o_blk_cnt, o_stall_cnt;
`endif

   conv_bf16tomx_seq #(.k(K), .bit_width(BW), .conv_lat(LAT), .out_depth(DEPTH)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_bf16(i_bf16),
      .i_last(i_last), .o_conv_vec(o_conv_vec), .o_conv_issue(o_conv_issue),
      .i_conv_mx_vec(i_conv_mx_vec), .i_conv_mx_exp(i_conv_mx_exp), .o_valid(o_valid),
      .i_ready(i_ready), .o_mx_vec(o_mx_vec), .o_mx_exp(o_mx_exp), .o_count(o_count)
`ifdef CONV_SEQ_PERF_CNT_EN
      , .o_blk_cnt(o_blk_cnt), .o_stall_cnt(o_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0, cyc = 0;
   int n_issue = 0, n_pop = 0, n_cappop = 0, n_vld = 0, n_nrdy = 0, last_cnt = 0;
   int issue_t[$];
   logic [16*K-1:0] last_cvec;
   bit rnd_ready = 0;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Mock converter: element = hi^lo byte of the bf16, exponent from element 0.
   function automatic logic [K*BW-1:0] mx_of(input logic [16*K-1:0] v);
      logic [K*BW-1:0] r;
      for (int j = 0; j < K; j++) r[8*j +: 8] = v[16*j +: 8] ^ v[16*j+8 +: 8];
      return r;
   endfunction
   function automatic logic [7:0] exp_of(input logic [16*K-1:0] v);
      return v[14:7] ^ 8'h5A;
   endfunction
   function automatic logic [K*BW-1:0] rnd_mx();
      logic [K*BW-1:0] r;
      for (int i = 0; i < K*BW/32; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   logic [K*BW-1:0] cp_v [1:LAT];
   logic [7:0]      cp_e [1:LAT];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      cp_v[1] <= o_conv_issue ? mx_of(o_conv_vec) : rnd_mx();
      cp_e[1] <= o_conv_issue ? exp_of(o_conv_vec) : 8'($urandom);
      for (int i = 2; i <= LAT; i++) begin
         cp_v[i] <= cp_v[i-1];
         cp_e[i] <= cp_e[i-1];
      end
   end
   assign i_conv_mx_vec = cp_v[LAT];
   assign i_conv_mx_exp = cp_e[LAT];

   // Reference model: elements -> padded blocks -> expected outputs, capture at issue+LAT.
   logic [15:0]     cur_q[$];
   logic [16*K-1:0] blk_q[$];
   int              bcnt_q[$];
   logic [K*BW-1:0] ev_q[$];
   logic [7:0]      ee_q[$];
   int              ec_q[$];
   int              cap_q[$];
   int              occ_m = 0;

   always @(negedge clk) begin
      if (rst) begin
         cur_q.delete(); blk_q.delete(); bcnt_q.delete();
         ev_q.delete(); ee_q.delete(); ec_q.delete(); cap_q.delete();
         occ_m = 0;
      end else begin
         while (cap_q.size() > 0 && cap_q[0] < cyc) begin
            occ_m++;
            void'(cap_q.pop_front());
         end
         chk("o_valid_vs_model", o_valid, occ_m > 0);
         if (o_valid) n_vld++;
         if (!o_ready) n_nrdy++;
         if (o_valid && i_ready) begin
            n_pop++;
            last_cnt = int'(o_count);
            if (cap_q.size() > 0 && cap_q[0] == cyc) n_cappop++;
            chk("pop_pending", ev_q.size() != 0, 1'b1);
            if (ev_q.size() != 0) begin
               chk("o_mx_vec", o_mx_vec, ev_q.pop_front());
               chk("o_mx_exp", o_mx_exp, ee_q.pop_front());
               chk("o_count", o_count, ec_q.pop_front());
            end
            occ_m--;
         end
         if (o_conv_issue) begin
            n_issue++;
            issue_t.push_back(cyc);
            last_cvec = o_conv_vec;
            chk("issue_pending", blk_q.size() != 0, 1'b1);
            if (blk_q.size() != 0) begin
               chk("o_conv_vec", o_conv_vec, blk_q[0]);
               ev_q.push_back(mx_of(blk_q[0]));
               ee_q.push_back(exp_of(blk_q[0]));
               ec_q.push_back(bcnt_q.pop_front());
               void'(blk_q.pop_front());
            end
            cap_q.push_back(cyc + LAT);
            chk("outstanding_le_depth", (cap_q.size() + occ_m) <= DEPTH, 1'b1);
         end
         if (i_valid && o_ready) begin
            cur_q.push_back(i_bf16);
            if (cur_q.size() == K || i_last) begin
               logic [16*K-1:0] pv;
               pv = '0;
               foreach (cur_q[j]) pv[16*j +: 16] = cur_q[j];
               blk_q.push_back(pv);
               bcnt_q.push_back(cur_q.size());
               cur_q.delete();
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_ready) i_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input logic [15:0] d, input logic last);
      int n = 0;
      logic acc = 1'b0;
      i_valid = 1'b1; i_bf16 = d; i_last = last;
      do begin
         @(negedge clk);
         acc = o_ready;
         tick();
         n++;
      end while (!acc && n < 300);
      chk("send_accept_timeout", acc, 1'b1);
   endtask

   task automatic idle();
      i_valid = 1'b0; i_last = 1'b0;
   endtask

   initial begin
      int t0, b0, p0, v0, r0, c0, tb;
      rst = 1'b1; i_valid = 1'b0; i_bf16 = '0; i_last = 1'b0; i_ready = 1'b0;
      repeat (2) tick();
      chk("rst_o_ready", o_ready, 1'b1);
      chk("rst_o_conv_issue", o_conv_issue, 1'b0);
      chk("rst_o_valid", o_valid, 1'b0);
      chk("rst_o_mx_vec", o_mx_vec, '0);
      chk("rst_o_mx_exp", o_mx_exp, '0);
      chk("rst_o_count", o_count, '0);
      chk("rst_o_conv_vec", o_conv_vec, '0);
`ifdef CONV_SEQ_PERF_CNT_EN
      chk("rst_blk_cnt", o_blk_cnt, '0);
      chk("rst_stall_cnt", o_stall_cnt, '0);
`endif
      rst = 1'b0;
      tick();

      // 64 back-to-back elements with the consumer always ready
      i_ready = 1'b1; b0 = n_issue; p0 = n_pop; r0 = n_nrdy; t0 = cyc;
      for (int i = 0; i < 64; i++) send(16'($urandom), 1'b0);
      idle();
      chk("b2b_cycles", cyc - t0, 64);
      repeat (LAT + 4) tick();
      chk("b2b_issues", n_issue - b0, 2);
      chk("b2b_spacing", issue_t[b0+1] - issue_t[b0], 32);
      chk("b2b_pops", n_pop - p0, 2);
      chk("b2b_count", last_cnt, 32);
      chk("b2b_ready_held", n_nrdy - r0, 0);

      // short block closed by i_last
      b0 = n_issue; p0 = n_pop;
      for (int i = 0; i < 5; i++) send(16'($urandom_range(1, 16'hFFFF)), i == 4);
      idle();
      repeat (LAT + 4) tick();
      chk("last_issues", n_issue - b0, 1);
      chk("last_pad_zero", last_cvec[16*K-1:80], '0);
      chk("last_count", last_cnt, 5);
      chk("last_pops", n_pop - p0, 1);

      // consumer stalled: two blocks buffered, third waits for credit
      i_ready = 1'b0; b0 = n_issue; p0 = n_pop;
      for (int i = 0; i < 96; i++) send(16'($urandom), 1'b0);
      idle();
      repeat (3) tick();
      chk("stall_ready_low", o_ready, 1'b0);
      chk("stall_valid", o_valid, 1'b1);
      chk("stall_issues", n_issue - b0, 2);
      i_ready = 1'b1;
      @(negedge clk);
      chk("credit_same_cycle_issue", o_conv_issue, 1'b1);
      tick();
      i_ready = 1'b0;
      chk("credit_back_to_fill", o_ready, 1'b1);
      repeat (LAT + 2) tick();
      chk("stall_issues_after", n_issue - b0, 3);
      i_ready = 1'b1;
      repeat (LAT + 6) tick();
      chk("stall_drain_pops", n_pop - p0, 3);
      chk("stall_drain_empty", ev_q.size(), 0);

      // pop of block A coincides with capture of block B
      i_ready = 1'b0; c0 = n_cappop;
      for (int i = 0; i < 4; i++) send(16'($urandom), i == 3);
      for (int i = 0; i < 2; i++) send(16'($urandom), i == 1);
      idle();
      chk("issue_after_close", o_conv_issue, 1'b1);
      repeat (LAT) tick();
      i_ready = 1'b1;
      @(negedge clk);
      chk("cappop_head_valid", o_valid, 1'b1);
      tick();
      i_ready = 1'b0;
      chk("cappop_occ_kept", o_valid, 1'b1);
      chk("cappop_seen", n_cappop - c0, 1);
      i_ready = 1'b1;
      repeat (LAT + 4) tick();
      chk("cappop_drained", ev_q.size(), 0);

      // random traffic with random consumer backpressure
      rnd_ready = 1; p0 = n_pop; b0 = n_issue;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin idle(); tick(); end
         send(16'($urandom), $urandom_range(0, 5) == 0);
      end
      send(16'($urandom), 1'b1);
      idle();
      rnd_ready = 0; i_ready = 1'b1;
      repeat (LAT + 8) tick();
      chk("rand_all_popped", n_pop - p0, n_issue - b0);
      chk("rand_model_empty", ev_q.size() + blk_q.size() + cur_q.size(), 0);

      // reset two cycles after an issue
      b0 = n_issue;
      for (int i = 0; i < K; i++) send(16'($urandom), 1'b0);
      idle();
      tb = 0;
      while (n_issue == b0 && tb < 10) begin tick(); tb++; end
      chk("pre_reset_issue", n_issue - b0, 1);
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      v0 = n_vld; p0 = n_pop;
      repeat (LAT + 10) tick();
      chk("post_reset_no_valid", n_vld - v0, 0);
      chk("post_reset_ready", o_ready, 1'b1);
      for (int i = 0; i < 3; i++) send(16'($urandom), i == 2);
      idle();
      repeat (LAT + 4) tick();
      chk("post_reset_block", n_pop - p0, 1);
      chk("post_reset_count", last_cnt, 3);

`ifdef CONV_SEQ_PERF_CNT_EN
      rst = 1'b1; tick(); rst = 1'b0; tick();
      i_ready = 1'b0;
      for (int i = 0; i < 96; i++) send(16'($urandom), 1'b0);
      idle();
      repeat (6) tick();
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      chk("perf_blk_cnt", o_blk_cnt, 32'd3);
      chk("perf_stall_cnt", o_stall_cnt, 32'd7);
      i_ready = 1'b1;
      repeat (LAT + 6) tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
